// File: rtl/constant_generator.sv
// MSP430 constant-generator decode: flags CG1 (R2) / CG2 (R3) operands and supplies their value, registered.
// Define CG_ABSOLUTE_EN to make R2 indexed (absolute mode) yield a generated 0x0000 base.
module constant_generator (
  input  logic        MCLK,
  input  logic        RSTn,
  input  logic        Format,
  input  logic [3:0]  srcA,
  input  logic [1:0]  As,
  input  logic [3:0]  dstA,
  input  logic        Ad,
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic        srcGenerated,
  output logic        dstGenerated
);

  localparam int unsigned DataW = 16;
  localparam int unsigned RegW  = 4;

  localparam logic [RegW-1:0] RegCg1 = RegW'(2);
  localparam logic [RegW-1:0] RegCg2 = RegW'(3);

`ifdef CG_ABSOLUTE_EN
  localparam bit AbsEnable = 1'b1;
`else
  localparam bit AbsEnable = 1'b0;
`endif

  logic [DataW-1:0] srcNext;
  logic [DataW-1:0] dstNext;
  logic             srcGenNext;
  logic             dstGenNext;

  // Source decode (both formats use srcA/As).
  always_comb begin
    srcNext    = '0;
    srcGenNext = 1'b0;
    if (srcA == RegCg1) begin
      unique case (As)
        2'b00: srcGenNext = 1'b0;
        2'b01: srcGenNext = AbsEnable;
        2'b10: begin srcGenNext = 1'b1; srcNext = DataW'(16'h0004); end
        2'b11: begin srcGenNext = 1'b1; srcNext = DataW'(16'h0008); end
        default: srcGenNext = 1'b0;
      endcase
    end else if (srcA == RegCg2) begin
      srcGenNext = 1'b1;
      unique case (As)
        2'b00: srcNext = DataW'(16'h0000);
        2'b01: srcNext = DataW'(16'h0001);
        2'b10: srcNext = DataW'(16'h0002);
        2'b11: srcNext = DataW'(16'hFFFF);
        default: srcNext = '0;
      endcase
    end
  end

  // Destination decode, Format I only.
  always_comb begin
    dstNext    = '0;
    dstGenNext = 1'b0;
    if (!Format) begin
      if (dstA == RegCg1) begin
        dstGenNext = Ad & AbsEnable;
      end else if (dstA == RegCg2) begin
        dstGenNext = 1'b1;
        dstNext    = Ad ? DataW'(16'h0001) : DataW'(16'h0000);
      end
    end
  end

  always_ff @(posedge MCLK or negedge RSTn) begin
    if (!RSTn) begin
      src          <= '0;
      dst          <= '0;
      srcGenerated <= 1'b0;
      dstGenerated <= 1'b0;
    end else begin
      src          <= srcNext;
      dst          <= dstNext;
      srcGenerated <= srcGenNext;
      dstGenerated <= dstGenNext;
    end
  end

endmodule

// File: tb/tb_constant_generator.sv
// Scoreboard bench for constant_generator: stimulus pushes hand-computed expectations, a monitor pops one per cycle.
module tb_constant_generator;

  logic        MCLK;
  logic        RSTn;
  logic        Format;
  logic [3:0]  srcA;
  logic [1:0]  As;
  logic [3:0]  dstA;
  logic        Ad;
  logic [15:0] src;
  logic [15:0] dst;
  logic        srcGenerated;
  logic        dstGenerated;

  int errors = 0;
  int checks = 0;

`ifdef CG_ABSOLUTE_EN
  localparam logic ABS = 1'b1;
`else
  localparam logic ABS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] eSrc;
    logic        eSg;
    logic [15:0] eDst;
    logic        eDg;
  } exp_t;

  exp_t sb[$];

  constant_generator dut (
    .MCLK(MCLK), .RSTn(RSTn), .Format(Format), .srcA(srcA), .As(As),
    .dstA(dstA), .Ad(Ad), .src(src), .dst(dst),
    .srcGenerated(srcGenerated), .dstGenerated(dstGenerated)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkVal({name, ".src"}, src, 16'h0000);
    checkVal({name, ".srcGen"}, 16'(srcGenerated), 16'h0000);
    checkVal({name, ".dst"}, dst, 16'h0000);
    checkVal({name, ".dstGen"}, 16'(dstGenerated), 16'h0000);
  endtask

  task automatic send(input string name, input logic fmt, input logic [3:0] sA, input logic [1:0] as,
                      input logic [3:0] dA, input logic ad, input logic [15:0] eSrc, input logic eSg,
                      input logic [15:0] eDst, input logic eDg);
    exp_t e;
    @(negedge MCLK);
    Format = fmt; srcA = sA; As = as; dstA = dA; Ad = ad;
    e.name = name; e.eSrc = eSrc; e.eSg = eSg; e.eDst = eDst; e.eDg = eDg;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge MCLK);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: outputs are valid every cycle after reset; compare the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge MCLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkVal({e.name, ".src"}, src, e.eSrc);
        checkVal({e.name, ".srcGen"}, 16'(srcGenerated), 16'(e.eSg));
        checkVal({e.name, ".dst"}, dst, e.eDst);
        checkVal({e.name, ".dstGen"}, 16'(dstGenerated), 16'(e.eDg));
      end
    end
  end

  initial begin
    RSTn = 1'b0; Format = 1'b0; srcA = 4'd3; As = 2'b11; dstA = 4'd4; Ad = 1'b0;
    #2;
    checkAllZero("reset_async");
    repeat (2) @(posedge MCLK);
    #1;
    checkAllZero("reset_clocked");

    @(negedge MCLK);
    RSTn = 1'b1;
    begin
      exp_t e;
      e.name = "rst_release"; e.eSrc = 16'hFFFF; e.eSg = 1'b1; e.eDst = 16'h0000; e.eDg = 1'b0;
      sb.push_back(e);
    end

    // Format I source sweep (dst R4 never generates)
    send("r4_as0", 0, 4'd4, 2'b00, 4'd4, 0, 16'h0000, 0, 16'h0000, 0);
    send("r4_as1", 0, 4'd4, 2'b01, 4'd4, 0, 16'h0000, 0, 16'h0000, 0);
    send("r4_as2", 0, 4'd4, 2'b10, 4'd4, 0, 16'h0000, 0, 16'h0000, 0);
    send("r4_as3", 0, 4'd4, 2'b11, 4'd4, 0, 16'h0000, 0, 16'h0000, 0);
    send("r2_as0", 0, 4'd2, 2'b00, 4'd4, 0, 16'h0000, 0, 16'h0000, 0);
    send("r2_as2", 0, 4'd2, 2'b10, 4'd4, 0, 16'h0004, 1, 16'h0000, 0);
    send("r2_as3", 0, 4'd2, 2'b11, 4'd4, 0, 16'h0008, 1, 16'h0000, 0);
    send("r3_as0", 0, 4'd3, 2'b00, 4'd4, 0, 16'h0000, 1, 16'h0000, 0);
    send("r3_as1", 0, 4'd3, 2'b01, 4'd4, 0, 16'h0001, 1, 16'h0000, 0);
    send("r3_as2", 0, 4'd3, 2'b10, 4'd4, 0, 16'h0002, 1, 16'h0000, 0);
    send("r3_as3", 0, 4'd3, 2'b11, 4'd4, 0, 16'hFFFF, 1, 16'h0000, 0);
    send("r15_as3", 0, 4'd15, 2'b11, 4'd4, 0, 16'h0000, 0, 16'h0000, 0);
    // Format I destination
    send("d_r3_ad0", 0, 4'd4, 2'b00, 4'd3, 0, 16'h0000, 0, 16'h0000, 1);
    send("d_r3_ad1", 0, 4'd4, 2'b00, 4'd3, 1, 16'h0000, 0, 16'h0001, 1);
    send("d_r5_ad1", 0, 4'd4, 2'b00, 4'd5, 1, 16'h0000, 0, 16'h0000, 0);
    send("d_r2_ad0", 0, 4'd4, 2'b00, 4'd2, 0, 16'h0000, 0, 16'h0000, 0);
    // Absolute mode
    send("abs_both", 0, 4'd2, 2'b01, 4'd2, 1, 16'h0000, ABS, 16'h0000, ABS);
    // Format II ignores destination
    send("f2_r3", 1, 4'd3, 2'b11, 4'd3, 1, 16'hFFFF, 1, 16'h0000, 0);
    send("f2_abs", 1, 4'd2, 2'b01, 4'd2, 1, 16'h0000, ABS, 16'h0000, 0);
    send("f2_r2_as2", 1, 4'd2, 2'b10, 4'd3, 0, 16'h0004, 1, 16'h0000, 0);
    // Simultaneous decodes
    send("sim_r2_r3", 0, 4'd2, 2'b11, 4'd3, 1, 16'h0008, 1, 16'h0001, 1);
    send("sim_r3_r2", 0, 4'd3, 2'b10, 4'd2, 1, 16'h0002, 1, 16'h0000, ABS);
    send("sim_r3_r3", 0, 4'd3, 2'b01, 4'd3, 1, 16'h0001, 1, 16'h0001, 1);
    drain();

    // Mid-stream reset: outputs were nonzero, must clear at once
    @(negedge MCLK);
    RSTn = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(posedge MCLK);
    #1;
    checkAllZero("mid_reset_edge");
    @(negedge MCLK);
    RSTn = 1'b1;
    begin
      exp_t e;
      e.name = "rst_recover"; e.eSrc = 16'h0001; e.eSg = 1'b1; e.eDst = 16'h0001; e.eDg = 1'b1;
      sb.push_back(e);
    end
    send("post_r2_as3", 0, 4'd2, 2'b11, 4'd0, 0, 16'h0008, 1, 16'h0000, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
